// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM states, failure codes and queue entry.
package mwc_pkg;

  localparam int MWC_ADDR_W = 32;
  localparam int MWC_DATA_W = 32;

  typedef enum logic [2:0] {IDLE, ARMED, PASS, FAIL} state_t;

  typedef enum logic [1:0] {FC_NONE, FC_MISADDR, FC_TIMEOUT, FC_UNEXP} fail_code_t;

  typedef struct packed {
    logic [MWC_ADDR_W-1:0] addr;
    logic [MWC_DATA_W-1:0] data;
  } exp_entry_t;

  function automatic logic is_final(state_t s);
    return (s == PASS) || (s == FAIL);
  endfunction

endpackage

// File: rtl/mwc_fifo.sv
// Small synchronous FIFO holding the expected writes; pointers wrap modulo DEPTH.
module mwc_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Ordered expected-write checker on the data-memory write port.
// Build option MWC_FAIL_CAPTURE_EN: latch offending address/data on the FAIL transition.
//
// state | meaning
// IDLE  | loading expected writes, waiting for start
// ARMED | comparing each memory write against the queue head
// PASS  | every expected write seen in order (sticky)
// FAIL  | misaddressed write, unexpected write or timeout (sticky)
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int STRICT      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       start,
  input  logic                       memwrite,
  input  logic [ADDR_W-1:0]          dataadr,
  input  logic [DATA_W-1:0]          writedata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data
);

  localparam int               CNT_W     = $clog2(DEPTH+1);
  localparam int               TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
  localparam bit               TMO_EN    = (TIMEOUT_CYC != 0);
  localparam bit               STRICT_EN = (STRICT != 0);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           head;
  logic             push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, cnt_nxt;
  logic             wr_hit, wr_misaddr, wr_other, tmo_hit;

  state_t           state_q, state_d;
  fail_code_t       fail_code_q, fail_code_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             exp_ready_q, exp_ready_d;

  mwc_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   ({exp_addr, exp_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign push       = exp_valid && exp_ready_q && !fifo_full && !clear;
  assign pop        = (state_q == ARMED) && wr_hit && !clear;
  assign wr_hit     = memwrite && (dataadr == head.addr) && (writedata == head.data);
  assign wr_misaddr = memwrite && (writedata == head.data) && (dataadr != head.addr);
  assign wr_other   = memwrite && STRICT_EN;
  assign tmo_hit    = TMO_EN && (tmr_q == '0);
  assign cnt_nxt    = clear ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);

  // Down-counter loaded on start; reaching zero on an ARMED edge is the timeout.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    match_cnt_d = match_cnt_q;
    tmr_d       = tmr_q;
    if (clear) begin
      state_d     = IDLE;
      fail_code_d = FC_NONE;
      match_cnt_d = '0;
      tmr_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = fifo_empty ? PASS : ARMED;
            tmr_d   = TMR_LOAD;
          end
        end
        ARMED: begin
          if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
          if (wr_hit) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
            if (fifo_count == CNT_W'(1)) state_d = PASS;
          end else if (wr_misaddr) begin
            state_d     = FAIL;
            fail_code_d = FC_MISADDR;
          end else if (wr_other) begin
            state_d     = FAIL;
            fail_code_d = FC_UNEXP;
          end else if (tmo_hit) begin
            state_d     = FAIL;
            fail_code_d = FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
    busy_d      = (state_d == ARMED);
    done_d      = is_final(state_d);
    pass_d      = (state_d == PASS);
    exp_ready_d = (state_d == IDLE) && (cnt_nxt < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fail_code_q <= FC_NONE;
      match_cnt_q <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      match_cnt_q <= match_cnt_d;
      tmr_q       <= tmr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exp_ready_q <= exp_ready_d;
    end
  end

  assign exp_ready = exp_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;

`ifdef MWC_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  // A timeout has no offending write, so the missing expected entry is reported instead.
  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (clear) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if ((state_q == ARMED) && (state_d == FAIL)) begin
      if (fail_code_d == FC_TIMEOUT) begin
        fail_addr_d = head.addr;
        fail_data_d = head.data;
      end else begin
        fail_addr_d = dataadr;
        fail_data_d = writedata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a lax and a strict instance share stimulus and a queue-based model.
module tb_mem_write_checker;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;
  localparam int S_IDLE = 0, S_ARMED = 1, S_PASS = 2, S_FAIL = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic        exp_valid = 1'b0, start = 1'b0, memwrite = 1'b0;
  logic [31:0] exp_addr = '0, exp_data = '0, dataadr = '0, writedata = '0;
  logic [1:0]  rdy_o, busy_o, done_o, pass_o;
  logic [1:0]  fc_o [2];
  logic [2:0]  mc_o [2];
  logic [31:0] fa_o [2];
  logic [31:0] fd_o [2];
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .STRICT(0)) u_lax (
    .clk(clk), .reset(reset), .clear(clear), .exp_valid(exp_valid), .exp_ready(rdy_o[0]),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .fail_code(fc_o[0]), .match_cnt(mc_o[0]), .fail_addr(fa_o[0]),
    .fail_data(fd_o[0]));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .STRICT(1)) u_strict (
    .clk(clk), .reset(reset), .clear(clear), .exp_valid(exp_valid), .exp_ready(rdy_o[1]),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .fail_code(fc_o[1]), .match_cnt(mc_o[1]), .fail_addr(fa_o[1]),
    .fail_data(fd_o[1]));

  // Reference model: list of loaded entries plus a per-instance head index.
  ent_t        ld[$];
  ent_t        m_h;
  int          m_st[2] = '{0, 0};
  int          m_hd[2] = '{0, 0};
  int          m_tc[2] = '{0, 0};
  logic [1:0]  m_fc[2] = '{2'd0, 2'd0};
  logic [2:0]  m_mc[2] = '{3'd0, 3'd0};
  logic [31:0] m_fa[2] = '{32'd0, 32'd0};
  logic [31:0] m_fd[2] = '{32'd0, 32'd0};
  logic        m_rdy = 1'b0;
  int          n0;

  task automatic m_zero(input int i);
    m_st[i] = S_IDLE; m_hd[i] = 0; m_tc[i] = 0;
    m_fc[i] = 2'd0; m_mc[i] = 3'd0; m_fa[i] = '0; m_fd[i] = '0;
  endtask

  task automatic m_fail(input int i, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    m_st[i] = S_FAIL; m_fc[i] = c; m_fa[i] = a; m_fd[i] = d;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld.delete();
      for (int i = 0; i < 2; i++) m_zero(i);
      m_rdy = 1'b0;
    end else if (clear) begin
      ld.delete();
      for (int i = 0; i < 2; i++) m_zero(i);
      m_rdy = 1'b1;
    end else if (m_st[0] == S_IDLE) begin
      n0 = ld.size();
      if (exp_valid && m_rdy) ld.push_back({exp_addr, exp_data});
      if (start) begin
        for (int i = 0; i < 2; i++) begin
          m_st[i] = (n0 == 0) ? S_PASS : S_ARMED;
          m_tc[i] = 0;
        end
      end
      m_rdy = (m_st[0] == S_IDLE) && (ld.size() < DEPTH);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_st[i] == S_ARMED) begin
          m_h = ld[m_hd[i]];
          m_tc[i]++;
          if (memwrite === 1'b1 && dataadr === m_h.a && writedata === m_h.d) begin
            m_hd[i]++;
            m_mc[i]++;
            if (m_hd[i] == ld.size()) m_st[i] = S_PASS;
          end else if (memwrite === 1'b1 && writedata === m_h.d) m_fail(i, 2'd1, dataadr, writedata);
          else if (memwrite === 1'b1 && i == 1) m_fail(i, 2'd3, dataadr, writedata);
          else if (m_tc[i] == TMO) m_fail(i, 2'd2, m_h.a, m_h.d);
        end
      end
      m_rdy = 1'b0;
    end
  end

  function automatic logic [72:0] exp_vec(input int i);
    logic [31:0] a, d;
    a = m_fa[i];
    d = m_fd[i];
`ifndef MWC_FAIL_CAPTURE_EN
    a = '0;
    d = '0;
`endif
    return {m_st[i] == S_ARMED, (m_st[i] == S_PASS) || (m_st[i] == S_FAIL), m_st[i] == S_PASS,
            m_fc[i], m_mc[i], m_rdy, a, d};
  endfunction

  function automatic logic [72:0] dut_vec(input int i);
    return {busy_o[i], done_o[i], pass_o[i], fc_o[i], mc_o[i], rdy_o[i], fa_o[i], fd_o[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d; tick(); exp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d; tick(); memwrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #3; reset = 1'b0; #4;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (dut_vec(i) !== 73'd0 || exp_vec(i) !== 73'd0) begin
        miscompares++;
        $display("FAIL reset[%0d] got %h want 0 (model %h)", i, dut_vec(i), exp_vec(i));
      end
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_basic();
    do_clear();
    load(32'h10, 32'hbbaab2d6);
    do_start();
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (busy_o[i] !== 1'b1 || done_o[i] !== 1'b0) begin
        miscompares++; $display("FAIL basic_armed[%0d] got busy=%b done=%b want 1 0", i, busy_o[i], done_o[i]);
      end
    end
    wr(32'h10, 32'hbbaab2d6);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({pass_o[i], done_o[i], busy_o[i], fc_o[i], mc_o[i]} !== {3'b110, 2'd0, 3'd1}) begin
        miscompares++;
        $display("FAIL basic_pass[%0d] got pass=%b done=%b busy=%b fc=%0d mc=%0d want 1 1 0 0 1",
                 i, pass_o[i], done_o[i], busy_o[i], fc_o[i], mc_o[i]);
      end
      vectors++;
      if (dut_vec(i) !== exp_vec(i)) begin
        miscompares++; $display("FAIL basic_model[%0d] got %h want %h", i, dut_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_misaddr();
    do_clear();
    load(32'h10, 32'hbbaab2d6);
    do_start();
    tick();
    wr(32'h14, 32'hbbaab2d6);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (fc_o[i] !== 2'd1 || done_o[i] !== 1'b1 || pass_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL misaddr[%0d] got fc=%0d done=%b pass=%b want 1 1 0", i, fc_o[i], done_o[i], pass_o[i]);
      end
`ifdef MWC_FAIL_CAPTURE_EN
      vectors++;
      if (fa_o[i] !== 32'h14 || fd_o[i] !== 32'hbbaab2d6) begin
        miscompares++;
        $display("FAIL misaddr_cap[%0d] got %h/%h want 00000014/bbaab2d6", i, fa_o[i], fd_o[i]);
      end
`endif
    end
  endtask

  task automatic test_ordered();
    do_clear();
    load(32'h0, 32'h1); load(32'h4, 32'h2); load(32'h8, 32'h3);
    do_start();
    wr(32'h0, 32'h1);
    wr(32'h20, 32'h55);
    vectors++;
    if (fc_o[1] !== 2'd3 || done_o[1] !== 1'b1 || mc_o[1] !== 3'd1) begin
      miscompares++;
      $display("FAIL ordered_strict got fc=%0d done=%b mc=%0d want 3 1 1", fc_o[1], done_o[1], mc_o[1]);
    end
    vectors++;
    if (busy_o[0] !== 1'b1 || mc_o[0] !== 3'd1 || fc_o[0] !== 2'd0) begin
      miscompares++;
      $display("FAIL ordered_lax_mid got busy=%b mc=%0d fc=%0d want 1 1 0", busy_o[0], mc_o[0], fc_o[0]);
    end
`ifdef MWC_FAIL_CAPTURE_EN
    vectors++;
    if (fa_o[1] !== 32'h20 || fd_o[1] !== 32'h55) begin
      miscompares++; $display("FAIL ordered_cap got %h/%h want 00000020/00000055", fa_o[1], fd_o[1]);
    end
`endif
    wr(32'h4, 32'h2);
    wr(32'h8, 32'h3);
    vectors++;
    if (pass_o[0] !== 1'b1 || mc_o[0] !== 3'd3) begin
      miscompares++; $display("FAIL ordered_lax_end got pass=%b mc=%0d want 1 3", pass_o[0], mc_o[0]);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (dut_vec(i) !== exp_vec(i)) begin
        miscompares++; $display("FAIL ordered_model[%0d] got %h want %h", i, dut_vec(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_timeout();
    do_clear();
    load(32'h40, 32'h1234);
    do_start();
    repeat (TMO - 1) tick();
    vectors++;
    if (busy_o[0] !== 1'b1 || fc_o[0] !== 2'd0) begin
      miscompares++; $display("FAIL timeout_early got busy=%b fc=%0d want 1 0", busy_o[0], fc_o[0]);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (fc_o[i] !== 2'd2 || done_o[i] !== 1'b1 || busy_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout[%0d] got fc=%0d done=%b busy=%b want 2 1 0", i, fc_o[i], done_o[i], busy_o[i]);
      end
`ifdef MWC_FAIL_CAPTURE_EN
      vectors++;
      if (fa_o[i] !== 32'h40 || fd_o[i] !== 32'h1234) begin
        miscompares++; $display("FAIL timeout_cap[%0d] got %h/%h want 00000040/00001234", i, fa_o[i], fd_o[i]);
      end
`endif
    end
    do_clear();
    load(32'h40, 32'h1234);
    do_start();
    repeat (TMO - 1) tick();
    wr(32'h40, 32'h1234);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pass_o[i] !== 1'b1 || fc_o[i] !== 2'd0 || mc_o[i] !== 3'd1) begin
        miscompares++;
        $display("FAIL timeout_last_match[%0d] got pass=%b fc=%0d mc=%0d want 1 0 1", i, pass_o[i], fc_o[i], mc_o[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_clear();
    exp_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_addr = 32'h100 + 32'(k * 4);
      exp_data = 32'ha0 + 32'(k);
      tick();
      vectors++;
      if (rdy_o[0] !== (k < 3) || rdy_o[1] !== (k < 3)) begin
        miscompares++; $display("FAIL overflow_ready push%0d got %b want %b", k, rdy_o, {2{k < 3}});
      end
    end
    exp_valid = 1'b0;
    do_start();
    for (int k = 0; k < 4; k++) wr(32'h100 + 32'(k * 4), 32'ha0 + 32'(k));
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pass_o[i] !== 1'b1 || mc_o[i] !== 3'd4) begin
        miscompares++; $display("FAIL overflow_pass[%0d] got pass=%b mc=%0d want 1 4", i, pass_o[i], mc_o[i]);
      end
    end
    do_clear();
    load(32'h8, 32'h9);
    do_start();
    tick();
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (dut_vec(i) !== 73'd0) begin
        miscompares++; $display("FAIL async_reset[%0d] got %h want 0", i, dut_vec(i));
      end
    end
    @(negedge clk); reset = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pass_o[i] !== 1'b1 || mc_o[i] !== 3'd0 || busy_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_queue_empty[%0d] got pass=%b mc=%0d busy=%b want 1 0 0", i, pass_o[i], mc_o[i], busy_o[i]);
      end
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (done_o[i] !== 1'b0 || rdy_o[i] !== 1'b1 || pass_o[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL clear[%0d] got done=%b ready=%b pass=%b want 0 1 0", i, done_o[i], rdy_o[i], pass_o[i]);
      end
    end
    do_start();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (pass_o[i] !== 1'b1 || done_o[i] !== 1'b1) begin
        miscompares++; $display("FAIL vacuous[%0d] got pass=%b done=%b want 1 1", i, pass_o[i], done_o[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int          r, j;
    for (int run = 0; run < 40; run++) begin
      do_clear();
      repeat ($urandom_range(1, 4)) begin
        a = 32'($urandom_range(0, 7)) << 2;
        d = 32'($urandom_range(0, 3));
        load(a, d);
      end
      do_start();
      for (int c = 0; c < 30 && (m_st[0] == S_ARMED || m_st[1] == S_ARMED); c++) begin
        r = $urandom_range(0, 99);
        j = (m_st[0] == S_ARMED) ? 0 : 1;
        m_h = ld[m_hd[j]];
        memwrite = 1'b0;
        if (r < 40) begin
          memwrite = 1'b1; dataadr = m_h.a; writedata = m_h.d;
        end else if (r < 50) begin
          memwrite = 1'b1; dataadr = m_h.a ^ 32'h4; writedata = m_h.d;
        end else if (r < 75) begin
          memwrite = 1'b1;
          dataadr = 32'($urandom_range(0, 7)) << 2;
          writedata = 32'($urandom_range(0, 3));
        end
        tick();
        memwrite = 1'b0;
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (dut_vec(i) !== exp_vec(i)) begin
            miscompares++;
            $display("FAIL random run%0d cyc%0d inst%0d got %h want %h", run, c, i, dut_vec(i), exp_vec(i));
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_misaddr();
    test_ordered();
    test_timeout();
    test_overflow();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
